// File: rtl/ar_rxd.sv
// ARINC 429 line receiver: recovers 32-bit words from the RXD1/RXD0 return-to-zero pair
// and flags gaps (truncated words), glitches and line conflicts.
`timescale 1ns/1ps
module ar_rxd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  Nvel,
  input  logic        RXD1,
  input  logic        RXD0,
  output logic [7:0]  ADR,
  output logic [22:0] DAT,
  output logic        ok_par,
  output logic        ce_wr,
  output logic        en_rx,
  output logic [5:0]  cb_bit,
  output logic        err_len,
  output logic        err_line
);

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_RECV = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic [10:0] half_bit_len(input logic [1:0] vel);
    logic [10:0] nt;
    case (vel)
      2'd3:    nt = 11'd25;
      2'd2:    nt = 11'd250;
      2'd1:    nt = 11'd500;
      default: nt = 11'd2000;
    endcase
    return nt;
  endfunction

  function automatic logic [22:0] rev23(input logic [22:0] v);
    logic [22:0] r;
    for (int i = 0; i < 23; i++) r[i] = v[22-i];
    return r;
  endfunction

  logic        rxd1_m_q, rxd0_m_q, s1_q, s0_q;
  logic [1:0]  state_q, state_d;
  logic [10:0] nt_q, nt_d, nt_live_s, nt_use_s, half_m1_s;
  logic [10:0] cb_hi_q, cb_hi_d;
  logic [12:0] cb_gap_q, cb_gap_d, thr3_s, thr4_s, gap_max_s;
  logic [13:0] nt8_s;
  logic [30:0] sr_q, sr_d;
  logic [31:0] word_s;
  logic        par_q, par_d;
  logic [7:0]  adr_q, adr_d;
  logic [22:0] dat_q, dat_d;
  logic        okp_q, okp_d, ce_wr_q, ce_wr_d, en_rx_q, en_rx_d;
  logic [5:0]  cb_bit_q, cb_bit_d;
  logic        err_len_q, err_len_d, err_line_q, err_line_d;
  logic        hi_s, conflict_s, accept_s;

  // Rate, thresholds and pulse/gap qualification; a word in flight keeps its latched rate
  always_comb begin
    nt_live_s  = half_bit_len(Nvel);
    nt_use_s   = (state_q == ST_RECV || state_q == ST_DONE) ? nt_q : nt_live_s;
    half_m1_s  = (nt_use_s >> 1) - 11'd1;
    thr3_s     = {2'b00, nt_use_s} * 13'd3;
    thr4_s     = {nt_use_s, 2'b00};
    nt8_s      = {nt_use_s, 3'b000};
    gap_max_s  = (nt8_s > 14'd8191) ? 13'h1FFF : nt8_s[12:0];
    hi_s       = s1_q | s0_q;
    conflict_s = s1_q & s0_q;
    accept_s   = hi_s && (cb_hi_q == half_m1_s);
    word_s     = {sr_q, s1_q};
    cb_hi_d    = hi_s ? ((cb_hi_q == 11'h7FF) ? cb_hi_q : cb_hi_q + 11'd1) : 11'd0;
    cb_gap_d   = hi_s ? 13'd0 : ((cb_gap_q >= gap_max_s) ? cb_gap_q : cb_gap_q + 13'd1);
  end

  // Word reception state machine
  always_comb begin
    state_d    = state_q;
    nt_d       = nt_q;
    sr_d       = sr_q;
    par_d      = par_q;
    cb_bit_d   = cb_bit_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    okp_d      = okp_q;
    en_rx_d    = en_rx_q;
    ce_wr_d    = 1'b0;
    err_len_d  = 1'b0;
    err_line_d = 1'b0;
    case (state_q)
      ST_SYNC: begin
        en_rx_d  = 1'b0;
        cb_bit_d = 6'd0;
        if (cb_gap_q >= thr4_s) begin
          state_d = ST_IDLE;
          nt_d    = nt_live_s;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_IDLE: begin
        if (accept_s && conflict_s) begin
          err_line_d = 1'b1;
          cb_bit_d   = 6'd0;
          state_d    = ST_SYNC;
        end else if (accept_s) begin
          state_d  = ST_RECV;
          nt_d     = nt_live_s;
          cb_bit_d = 6'd1;
          sr_d     = {30'd0, s1_q};
          par_d    = s1_q;
          en_rx_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (accept_s && conflict_s) begin
          err_line_d = 1'b1;
          cb_bit_d   = 6'd0;
          en_rx_d    = 1'b0;
          state_d    = ST_SYNC;
        end else if (accept_s && cb_bit_q == 6'd31) begin
          // First line bit lands in word_s[31]; data goes out LSB first after the address
          state_d  = ST_DONE;
          cb_bit_d = 6'd32;
          adr_d    = word_s[31:24];
          dat_d    = rev23(word_s[23:1]);
          okp_d    = par_q ^ s1_q;
          ce_wr_d  = 1'b1;
          en_rx_d  = 1'b0;
        end else if (accept_s) begin
          cb_bit_d = cb_bit_q + 6'd1;
          sr_d     = word_s[30:0];
          par_d    = par_q ^ s1_q;
        end else if (cb_gap_q >= thr3_s) begin
          err_len_d = 1'b1;
          cb_bit_d  = 6'd0;
          en_rx_d   = 1'b0;
          state_d   = ST_SYNC;
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_DONE: begin
        state_d  = ST_SYNC;
        cb_bit_d = 6'd0;
      end
      default: begin
        state_d  = ST_SYNC;
        cb_bit_d = 6'd0;
        en_rx_d  = 1'b0;
      end
    endcase
  end

  // Line synchronizers, counters, state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd1_m_q   <= 1'b0;
      rxd0_m_q   <= 1'b0;
      s1_q       <= 1'b0;
      s0_q       <= 1'b0;
      state_q    <= ST_SYNC;
      nt_q       <= 11'd2000;
      cb_hi_q    <= 11'd0;
      cb_gap_q   <= 13'd0;
      sr_q       <= 31'd0;
      par_q      <= 1'b0;
      adr_q      <= 8'd0;
      dat_q      <= 23'd0;
      okp_q      <= 1'b0;
      ce_wr_q    <= 1'b0;
      en_rx_q    <= 1'b0;
      cb_bit_q   <= 6'd0;
      err_len_q  <= 1'b0;
      err_line_q <= 1'b0;
    end else begin
      rxd1_m_q   <= RXD1;
      rxd0_m_q   <= RXD0;
      s1_q       <= rxd1_m_q;
      s0_q       <= rxd0_m_q;
      state_q    <= state_d;
      nt_q       <= nt_d;
      cb_hi_q    <= cb_hi_d;
      cb_gap_q   <= cb_gap_d;
      sr_q       <= sr_d;
      par_q      <= par_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      okp_q      <= okp_d;
      ce_wr_q    <= ce_wr_d;
      en_rx_q    <= en_rx_d;
      cb_bit_q   <= cb_bit_d;
      err_len_q  <= err_len_d;
      err_line_q <= err_line_d;
    end
  end

  assign ADR      = adr_q;
  assign DAT      = dat_q;
  assign ok_par   = okp_q;
  assign ce_wr    = ce_wr_q;
  assign en_rx    = en_rx_q;
  assign cb_bit   = cb_bit_q;
  assign err_len  = err_len_q;
  assign err_line = err_line_q;

endmodule

// File: tb/tb_ar_rxd.sv
// Scoreboard bench for ar_rxd: stimulus pushes expected strobes/probes, a negedge monitor compares.
`timescale 1ns/1ps
module tb_ar_rxd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  Nvel = 2'd3;
  logic        RXD1 = 1'b0;
  logic        RXD0 = 1'b0;
  logic [7:0]  ADR;
  logic [22:0] DAT;
  logic        ok_par, ce_wr, en_rx, err_len, err_line;
  logic [5:0]  cb_bit;

  ar_rxd dut (
    .clk(clk), .rst_n(rst_n), .Nvel(Nvel), .RXD1(RXD1), .RXD0(RXD0),
    .ADR(ADR), .DAT(DAT), .ok_par(ok_par), .ce_wr(ce_wr), .en_rx(en_rx),
    .cb_bit(cb_bit), .err_len(err_len), .err_line(err_line)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; logic [7:0] adr; logic [22:0] dat; logic okp; } exp_t;
  typedef struct { string name; int act; int lo; int hi; } probe_t;

  exp_t   sb[$];
  probe_t pq[$];
  int     n_cmp = 0;
  int     n_err = 0;

  function automatic void expect_ev(int kind, logic [7:0] a, logic [22:0] d, logic p);
    exp_t e;
    e.kind = kind; e.adr = a; e.dat = d; e.okp = p;
    sb.push_back(e);
  endfunction

  function automatic void probe(string nm, int act, int lo, int hi);
    probe_t p;
    p.name = nm; p.act = act; p.lo = lo; p.hi = hi;
    pq.push_back(p);
  endfunction

  // Monitor: settles probes and matches every DUT strobe against the scoreboard
  always @(negedge clk) begin
    probe_t p;
    exp_t   e;
    logic [2:0] act_code, exp_code;
    while (pq.size() > 0) begin
      p = pq.pop_front();
      n_cmp++;
      if (p.act < p.lo || p.act > p.hi) begin
        n_err++;
        $display("FAIL %s: got %0d, want %0d..%0d", p.name, p.act, p.lo, p.hi);
      end
    end
    if (rst_n && (ce_wr || err_len || err_line)) begin
      act_code = {ce_wr, err_len, err_line};
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got code=%b adr=%h dat=%h, want none", act_code, ADR, DAT);
      end else begin
        e = sb.pop_front();
        exp_code = (e.kind == 0) ? 3'b100 : ((e.kind == 1) ? 3'b010 : 3'b001);
        if (act_code != exp_code ||
            (e.kind == 0 && (ADR != e.adr || DAT != e.dat || ok_par != e.okp))) begin
          n_err++;
          $display("FAIL event: got code=%b adr=%h dat=%h okp=%b, want code=%b adr=%h dat=%h okp=%b",
                   act_code, ADR, DAT, ok_par, exp_code, e.adr, e.dat, e.okp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input logic b1, input logic b0, input int n);
    RXD1 = b1; RXD0 = b0;
    tick(n);
    RXD1 = 1'b0; RXD0 = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int nt, input bit glitch);
    pulse(b, ~b, nt);
    if (glitch) begin
      tick(10);
      pulse(1'b1, 1'b0, 5);
      tick(nt - 15);
    end else begin
      tick(nt);
    end
  endtask

  task automatic send_word(input logic [7:0] a, input logic [22:0] d, input bit bad_par,
                           input int nt, input int nbits, input int conflict_at, input bit glitch);
    logic b;
    for (int i = 1; i <= nbits; i++) begin
      if (i <= 8)       b = a[8-i];
      else if (i <= 31) b = d[i-9];
      else              b = ~(^{a, d}) ^ bad_par;
      if (i == conflict_at) begin
        pulse(1'b1, 1'b1, nt);
        tick(nt);
      end else begin
        send_bit(b, nt, glitch);
      end
    end
  endtask

  task automatic wait_err_len(input int bound, output int cnt);
    cnt = 0;
    while (!err_len && cnt < bound) begin
      tick(1);
      cnt++;
    end
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    tick(5);
    probe("rst_ADR", int'(ADR), 0, 0);
    probe("rst_DAT", int'(DAT), 0, 0);
    probe("rst_ok_par", int'(ok_par), 0, 0);
    probe("rst_ce_wr", int'(ce_wr), 0, 0);
    probe("rst_en_rx", int'(en_rx), 0, 0);
    probe("rst_cb_bit", int'(cb_bit), 0, 0);
    probe("rst_err_len", int'(err_len), 0, 0);
    probe("rst_err_line", int'(err_line), 0, 0);
    rst_n = 1'b1;
    tick(200);

    // Nvel=3: good word, then parity-inverted word
    expect_ev(0, 8'hA5, 23'h2AAAAA, 1'b1);
    send_word(8'hA5, 23'h2AAAAA, 1'b0, 25, 32, 0, 1'b0);
    tick(10);
    probe("cb_bit_after_word", int'(cb_bit), 0, 0);
    probe("en_rx_after_word", int'(en_rx), 0, 0);
    tick(190);
    expect_ev(0, 8'hA5, 23'h2AAAAA, 1'b0);
    send_word(8'hA5, 23'h2AAAAA, 1'b1, 25, 32, 0, 1'b0);
    tick(200);

    // Glitches between bits, then line conflict at bit 10
    expect_ev(0, 8'h3C, 23'h012345, 1'b1);
    send_word(8'h3C, 23'h012345, 1'b0, 25, 32, 0, 1'b1);
    tick(200);
    expect_ev(2, 8'h00, 23'h0, 1'b0);
    send_word(8'hC3, 23'h054321, 1'b0, 25, 32, 10, 1'b0);
    tick(200);
    probe("ADR_hold_after_line_err", int'(ADR), 8'h3C, 8'h3C);

    // Reset in the middle of bit 15, then a full word
    send_word(8'h5A, 23'h001234, 1'b0, 25, 14, 0, 1'b0);
    probe("cb_bit_mid_word", int'(cb_bit), 14, 14);
    probe("en_rx_mid_word", int'(en_rx), 1, 1);
    RXD1 = 1'b1;
    tick(8);
    rst_n = 1'b0;
    tick(2);
    probe("midrst_ADR", int'(ADR), 0, 0);
    probe("midrst_DAT", int'(DAT), 0, 0);
    probe("midrst_ok_par", int'(ok_par), 0, 0);
    probe("midrst_en_rx", int'(en_rx), 0, 0);
    probe("midrst_cb_bit", int'(cb_bit), 0, 0);
    RXD1 = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(200);
    expect_ev(0, 8'h81, 23'h7FFFFF, 1'b1);
    send_word(8'h81, 23'h7FFFFF, 1'b0, 25, 32, 0, 1'b0);
    tick(200);

    // Nvel=2: 20 bits then silence -> err_len about 3*Nt after the last pulse
    Nvel = 2'd2;
    expect_ev(1, 8'h00, 23'h0, 1'b0);
    send_word(8'hE7, 23'h00F0F0, 1'b0, 250, 19, 0, 1'b0);
    probe("cb_bit_19", int'(cb_bit), 19, 19);
    probe("en_rx_19", int'(en_rx), 1, 1);
    pulse(1'b1, 1'b0, 250);
    wait_err_len(1000, cnt);
    probe("err_len_latency_nvel2", cnt, 750, 755);

    // Nvel=0: 999-cycle pulse is a glitch, 1000-cycle pulse is a bit
    Nvel = 2'd0;
    tick(7600);
    pulse(1'b1, 1'b0, 999);
    tick(20);
    probe("cb_bit_after_999", int'(cb_bit), 0, 0);
    probe("en_rx_after_999", int'(en_rx), 0, 0);
    expect_ev(1, 8'h00, 23'h0, 1'b0);
    pulse(1'b1, 1'b0, 1000);
    tick(20);
    probe("cb_bit_after_1000", int'(cb_bit), 1, 1);
    probe("en_rx_after_1000", int'(en_rx), 1, 1);
    wait_err_len(6500, cnt);
    probe("err_len_latency_nvel0", cnt + 20, 6000, 6005);

    // Nvel=3: back-to-back words with a 7*Nt low gap
    Nvel = 2'd3;
    tick(200);
    expect_ev(0, 8'h12, 23'h345678, 1'b1);
    send_word(8'h12, 23'h345678, 1'b0, 25, 32, 0, 1'b0);
    tick(150);
    expect_ev(0, 8'hFF, 23'h000000, 1'b1);
    send_word(8'hFF, 23'h000000, 1'b0, 25, 32, 0, 1'b0);
    tick(150);
    expect_ev(0, 8'h00, 23'h400001, 1'b1);
    send_word(8'h00, 23'h400001, 1'b0, 25, 32, 0, 1'b0);
    tick(150);

    probe("scoreboard_left", sb.size(), 0, 0);
    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
